// File: rtl/edit_mem_buf_client.sv
// edit_mem_buf_client
//   PU-side client of the edit-memory free-buffer allocator.
//   - Runs the allocator init handshake (freeb_init pulse, wait for freeb_init_done).
//   - Prefetches buffer pointers into a small FIFO cache so the PU gets single-cycle grants.
//   - Forwards PU buffer releases to the allocator one cycle later.
// Ports
//   clk, rst                          clock, asynchronous active-high reset
//   start_init                        pulse: (re)initialise allocator, flush cache
//   init_done                         client is in RUN
//   freeb_init / freeb_init_done      allocator init handshake
//   pu_buf_req                        prefetch request (one pointer per asserted cycle)
//   pu_buf_valid/available/ptr        allocator response, 3 cycles after a request
//   rel_buf_valid / rel_buf_ptr       release strobe to allocator
//   alloc_req / alloc_gnt / alloc_ptr PU allocation (combinational grant, head of cache)
//   free_valid / free_ptr             PU buffer return
//   cache_count                       number of cached pointers
//   miss_count                        saturating count of available=0 responses

// Simulation-only invariants for the pointer cache credit scheme.
module edit_mem_buf_client_chk #(
    parameter int CACHE_DEPTH = 4,
    parameter int CNT_W       = 3
) (
    input logic             clk,
    input logic             rst,
    input logic [CNT_W-1:0] count,
    input logic [CNT_W-1:0] outstanding,
    input logic             wr,
    input logic             gnt
);
    // A response can never land on a full cache, and credit is never over-committed.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(wr && !gnt && (count == CNT_W'(CACHE_DEPTH))));
            assert (outstanding <= CNT_W'(CACHE_DEPTH));
        end
    end
endmodule

module edit_mem_buf_client #(
    parameter int BPTR_NBITS  = 8,
    parameter int CACHE_DEPTH = 4,
    parameter int BACKOFF     = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_init,
    output logic                                 init_done,
    output logic                                 freeb_init,
    input  logic                                 freeb_init_done,
    output logic                                 pu_buf_req,
    input  logic                                 pu_buf_valid,
    input  logic                                 pu_buf_available,
    input  logic [BPTR_NBITS-1:0]                pu_buf_ptr,
    output logic                                 rel_buf_valid,
    output logic [BPTR_NBITS-1:0]                rel_buf_ptr,
    input  logic                                 alloc_req,
    output logic                                 alloc_gnt,
    output logic [BPTR_NBITS-1:0]                alloc_ptr,
    input  logic                                 free_valid,
    input  logic [BPTR_NBITS-1:0]                free_ptr,
    output logic [$clog2(CACHE_DEPTH+1)-1:0]     cache_count,
    output logic [15:0]                          miss_count
);
    localparam int IDX_W = $clog2(CACHE_DEPTH);
    localparam int CNT_W = $clog2(CACHE_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam int BO_W  = $clog2(BACKOFF + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT_REQ  = 3'd1,
        ST_WAIT_LOW  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    state_t                state_r;
    logic                  init_done_r;
    logic                  freeb_init_r;
    logic                  req_r;
    logic [CNT_W-1:0]      out_r;
    logic [CNT_W-1:0]      count_r;
    logic [IDX_W-1:0]      head_r;
    logic [IDX_W-1:0]      tail_r;
    logic [BO_W-1:0]       backoff_r;
    logic [15:0]           miss_r;
    logic                  rel_valid_r;
    logic [BPTR_NBITS-1:0] rel_ptr_r;
    logic [BPTR_NBITS-1:0] mem_r [CACHE_DEPTH];

    logic                  run_s;
    logic                  flush_s;
    logic                  gnt_s;
    logic                  wr_s;
    logic                  miss_s;
    logic                  rsp_s;
    logic [CNT_W-1:0]      out_next_s;
    logic [CNT_W-1:0]      count_next_s;
    logic [BO_W-1:0]       backoff_next_s;
    logic [SUM_W-1:0]      credit_s;
    logic                  req_next_s;

    // Next-cycle credit terms; the request being issued this cycle (req_r) is already counted.
    always_comb begin
        run_s   = (state_r == ST_RUN);
        flush_s = start_init && ((state_r == ST_IDLE) || run_s);
        gnt_s   = alloc_req && run_s && (count_r != '0);
        wr_s    = pu_buf_valid && pu_buf_available && run_s;
        miss_s  = pu_buf_valid && !pu_buf_available && run_s;
        // Late responses with nothing outstanding (e.g. after reset) are ignored.
        rsp_s   = pu_buf_valid && (out_r != '0);
        out_next_s = out_r + CNT_W'(req_r) - CNT_W'(rsp_s);
        if (flush_s) begin
            count_next_s = '0;
        end else begin
            count_next_s = count_r + CNT_W'(wr_s) - CNT_W'(gnt_s);
        end
        if (miss_s) begin
            backoff_next_s = BO_W'(BACKOFF);
        end else if (backoff_r != '0) begin
            backoff_next_s = backoff_r - BO_W'(1);
        end else begin
            backoff_next_s = '0;
        end
        credit_s   = SUM_W'(count_next_s) + SUM_W'(out_next_s);
        req_next_s = run_s && !start_init && (backoff_next_s == '0) &&
                     (credit_s < SUM_W'(CACHE_DEPTH));
    end

    // Init handshake FSM with registered init_done / freeb_init.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            init_done_r  <= 1'b0;
            freeb_init_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_init) begin
                        state_r      <= ST_INIT_REQ;
                        freeb_init_r <= 1'b1;
                    end
                end
                ST_INIT_REQ: begin
                    state_r      <= ST_WAIT_LOW;
                    freeb_init_r <= 1'b0;
                end
                ST_WAIT_LOW: begin
                    if (!freeb_init_done) begin
                        state_r <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (freeb_init_done && (out_r == '0)) begin
                        state_r     <= ST_RUN;
                        init_done_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (start_init) begin
                        state_r      <= ST_INIT_REQ;
                        init_done_r  <= 1'b0;
                        freeb_init_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    init_done_r  <= 1'b0;
                    freeb_init_r <= 1'b0;
                end
            endcase
        end
    end

    // Prefetch request, outstanding/credit, cache pointers, backoff, miss and release registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_r       <= 1'b0;
            out_r       <= '0;
            count_r     <= '0;
            head_r      <= '0;
            tail_r      <= '0;
            backoff_r   <= '0;
            miss_r      <= 16'h0000;
            rel_valid_r <= 1'b0;
            rel_ptr_r   <= '0;
        end else begin
            req_r     <= req_next_s;
            out_r     <= out_next_s;
            count_r   <= count_next_s;
            backoff_r <= backoff_next_s;
            if (flush_s) begin
                head_r <= '0;
                tail_r <= '0;
            end else begin
                if (wr_s) begin
                    tail_r <= tail_r + IDX_W'(1);
                end
                if (gnt_s) begin
                    head_r <= head_r + IDX_W'(1);
                end
            end
            if (miss_s && (miss_r != 16'hFFFF)) begin
                miss_r <= miss_r + 16'd1;
            end
            rel_valid_r <= free_valid && run_s;
            if (free_valid && run_s) begin
                rel_ptr_r <= free_ptr;
            end
        end
    end

    // Cache storage; contents are only meaningful between head and tail, so no reset.
    always_ff @(posedge clk) begin
        if (wr_s && !flush_s) begin
            mem_r[tail_r] <= pu_buf_ptr;
        end
    end

    assign init_done     = init_done_r;
    assign freeb_init    = freeb_init_r;
    assign pu_buf_req    = req_r;
    assign rel_buf_valid = rel_valid_r;
    assign rel_buf_ptr   = rel_ptr_r;
    assign alloc_gnt     = gnt_s;
    assign alloc_ptr     = mem_r[head_r];
    assign cache_count   = count_r;
    assign miss_count    = miss_r;

    edit_mem_buf_client_chk #(
        .CACHE_DEPTH (CACHE_DEPTH),
        .CNT_W       (CNT_W)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .count       (count_r),
        .outstanding (out_r),
        .wr          (wr_s),
        .gnt         (gnt_s)
    );
endmodule

// File: tb/tb_edit_mem_buf_client.sv
module tb_edit_mem_buf_client;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_init;
    logic        init_done;
    logic        freeb_init;
    logic        freeb_init_done;
    logic        pu_buf_req;
    logic        pu_buf_valid;
    logic        pu_buf_available;
    logic [7:0]  pu_buf_ptr;
    logic        rel_buf_valid;
    logic [7:0]  rel_buf_ptr;
    logic        alloc_req;
    logic        alloc_gnt;
    logic [7:0]  alloc_ptr;
    logic        free_valid;
    logic [7:0]  free_ptr;
    logic [2:0]  cache_count;
    logic [15:0] miss_count;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Allocator model: request history (3-cycle response latency) and pointer source.
    logic        hist [3];
    logic [7:0]  next_ptr;
    logic        alloc_empty;

    edit_mem_buf_client #(
        .BPTR_NBITS  (8),
        .CACHE_DEPTH (4),
        .BACKOFF     (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start_init       (start_init),
        .init_done        (init_done),
        .freeb_init       (freeb_init),
        .freeb_init_done  (freeb_init_done),
        .pu_buf_req       (pu_buf_req),
        .pu_buf_valid     (pu_buf_valid),
        .pu_buf_available (pu_buf_available),
        .pu_buf_ptr       (pu_buf_ptr),
        .rel_buf_valid    (rel_buf_valid),
        .rel_buf_ptr      (rel_buf_ptr),
        .alloc_req        (alloc_req),
        .alloc_gnt        (alloc_gnt),
        .alloc_ptr        (alloc_ptr),
        .free_valid       (free_valid),
        .free_ptr         (free_ptr),
        .cache_count      (cache_count),
        .miss_count       (miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; 1 ns after the edge update the allocator response for the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        pu_buf_valid     = hist[2];
        pu_buf_available = hist[2] && !alloc_empty;
        pu_buf_ptr       = (hist[2] && !alloc_empty) ? next_ptr : 8'h00;
        if (hist[2] && !alloc_empty) begin
            next_ptr = next_ptr + 8'd1;
        end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = pu_buf_req;
    endtask

    task automatic wait_full(input string tag);
        for (int i = 0; i < 60; i++) begin
            #1;
            if (cache_count == 3'd4) break;
            tick();
        end
        chk(tag, cache_count, 4);
    endtask

    task automatic wait_valid(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (pu_buf_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, found, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".init_done"}, init_done, 0);
        chk({tag, ".freeb_init"}, freeb_init, 0);
        chk({tag, ".pu_buf_req"}, pu_buf_req, 0);
        chk({tag, ".rel_buf_valid"}, rel_buf_valid, 0);
        chk({tag, ".rel_buf_ptr"}, rel_buf_ptr, 0);
        chk({tag, ".alloc_gnt"}, alloc_gnt, 0);
        chk({tag, ".cache_count"}, cache_count, 0);
        chk({tag, ".miss_count"}, miss_count, 0);
    endtask

    initial begin
        int nreq;
        int first;
        int last;
        int lows;
        int got;
        logic [7:0] exp_ptr [3];

        rst = 1'b1;
        start_init = 1'b0;
        freeb_init_done = 1'b0;
        pu_buf_valid = 1'b0;
        pu_buf_available = 1'b0;
        pu_buf_ptr = 8'h00;
        alloc_req = 1'b0;
        free_valid = 1'b0;
        free_ptr = 8'h00;
        hist[0] = 1'b0;
        hist[1] = 1'b0;
        hist[2] = 1'b0;
        next_ptr = 8'h05;
        alloc_empty = 1'b0;

        // Reset state
        tick();
        tick();
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // 1. Init handshake and initial prefetch of 4 pointers
        tick();
        start_init = 1'b1;
        tick();
        start_init = 1'b0;
        #1;
        chk("init.freeb_init_pulse", freeb_init, 1);
        tick();
        #1;
        chk("init.freeb_init_one_cycle", freeb_init, 0);
        tick();
        freeb_init_done = 1'b1;
        #1;
        chk("init.not_done_yet", init_done, 0);
        tick();
        #1;
        chk("init.init_done", init_done, 1);
        nreq = 0;
        first = -1;
        last = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            #1;
            if (pu_buf_req) begin
                nreq++;
                if (first < 0) first = i;
                last = i;
            end
        end
        chk("init.req_count", nreq, 4);
        chk("init.req_back_to_back", last - first + 1, 4);
        chk("init.cache_count", cache_count, 4);

        // 2. Drain a full cache with alloc_req held; refill starts after the first grant
        alloc_req = 1'b1;
        #1;
        chk("drain.gnt0", alloc_gnt, 1);
        chk("drain.ptr0", alloc_ptr, 8'h05);
        chk("drain.no_req_full", pu_buf_req, 0);
        tick();
        #1;
        chk("drain.ptr1", alloc_gnt ? alloc_ptr : 8'hFF, 8'h06);
        chk("drain.refill_req", pu_buf_req, 1);
        tick();
        #1;
        chk("drain.ptr2", alloc_gnt ? alloc_ptr : 8'hFF, 8'h07);
        tick();
        #1;
        chk("drain.ptr3", alloc_gnt ? alloc_ptr : 8'hFF, 8'h08);
        tick();
        #1;
        chk("drain.empty_no_gnt", alloc_gnt, 0);
        chk("drain.empty_count", cache_count, 0);
        alloc_req = 1'b0;
        wait_full("drain.refilled");

        // 3. available=0 response -> exactly 8 idle request cycles, one miss
        alloc_empty = 1'b1;
        alloc_req = 1'b1;
        #1;
        chk("miss.gnt_ptr9", alloc_gnt ? alloc_ptr : 8'hFF, 8'h09);
        tick();
        alloc_req = 1'b0;
        wait_valid("miss.response_seen");
        chk("miss.available_low", pu_buf_available, 0);
        alloc_empty = 1'b0;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            #1;
            if (pu_buf_req) break;
            lows++;
        end
        chk("miss.backoff_cycles", lows, 8);
        chk("miss.miss_count", miss_count, 1);
        wait_full("miss.refilled");

        // 4. Release forwarding in RUN
        tick();
        free_valid = 1'b1;
        free_ptr = 8'h2A;
        #1;
        chk("rel.not_same_cycle", rel_buf_valid, 0);
        tick();
        free_valid = 1'b0;
        #1;
        chk("rel.valid", rel_buf_valid, 1);
        chk("rel.ptr", rel_buf_ptr, 8'h2A);
        tick();
        #1;
        chk("rel.one_cycle", rel_buf_valid, 0);

        // 5. Re-init with 3 requests in flight; in-flight pointers 0x40..0x42 are discarded
        next_ptr = 8'h40;
        tick();
        alloc_req = 1'b1;
        tick();
        tick();
        tick();
        alloc_req = 1'b0;
        start_init = 1'b1;
        tick();
        start_init = 1'b0;
        #1;
        chk("reinit.freeb_init", freeb_init, 1);
        chk("reinit.flushed", cache_count, 0);
        chk("reinit.init_done_low", init_done, 0);
        tick();
        freeb_init_done = 1'b0;
        tick();
        freeb_init_done = 1'b1;
        free_valid = 1'b1;
        free_ptr = 8'h2A;
        tick();
        free_valid = 1'b0;
        #1;
        chk("reinit.no_rel_outside_run", rel_buf_valid, 0);
        chk("reinit.wait_outstanding", init_done, 0);
        chk("reinit.discarded", cache_count, 0);
        tick();
        #1;
        chk("reinit.run", init_done, 1);
        for (int i = 0; i < 12; i++) begin
            if (cache_count != 3'd0) break;
            tick();
            #1;
        end
        chk("reinit.first_new_ptr", alloc_ptr, 8'h43);
        wait_full("reinit.refilled");

        // 6. Grant and write together at count 2; FIFO order kept
        tick();
        alloc_req = 1'b1;
        tick();
        tick();
        alloc_req = 1'b0;
        wait_valid("simul.response_seen");
        alloc_req = 1'b1;
        #1;
        chk("simul.count_before", cache_count, 2);
        chk("simul.gnt_ptr", alloc_gnt ? alloc_ptr : 8'hFF, 8'h45);
        chk("simul.write_ptr", pu_buf_ptr, 8'h47);
        tick();
        #1;
        chk("simul.count_stays", cache_count, 2);
        exp_ptr[0] = 8'h46;
        exp_ptr[1] = 8'h47;
        exp_ptr[2] = 8'h48;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (alloc_gnt) begin
                chk("simul.fifo_order", alloc_ptr, exp_ptr[got]);
                got++;
            end
            if (got == 3) break;
            tick();
        end
        chk("simul.fifo_grants", got, 3);

        // Reset while refill requests are in flight
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        tick();
        tick();
        rst = 1'b0;
        alloc_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        #1;
        chk_all_zero("postreset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
